// File: rtl/hazard_pkg.sv
// Shared types for the hazard/scoreboard unit: EX operand mux encoding and result-source codes.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_LNG = 2'b11
    } fwd_sel_e;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

endpackage

// File: rtl/fwd_select.sv
// Per-operand EX forwarding select; purely combinational, zero latency, no backpressure.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] mem_rd,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic          wb_reg_write,
    input  logic          lng_done,
    input  logic [RW-1:0] lng_done_rd,
    output fwd_sel_e      sel
);

    // Youngest producer wins; x0 is hardwired so it is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (rs != '0) begin
            if (lng_done && (lng_done_rd == rs)) begin
                sel = FWD_LNG;
            end else if (mem_reg_write && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (wb_reg_write && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use/scoreboard stalls, flushes, EX forwarding, stall-cycle counter.
// Stalls/flushes/forwarding are combinational (zero latency); scoreboard updates show the cycle after issue.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int  NREGS   = 32,
    parameter int  NREAD   = 2,
    parameter int  MAX_OUT = 4,
    parameter int  PERF_W  = 16,
    localparam int RW      = $clog2(NREGS),
    localparam int OW      = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREAD*RW-1:0] de_rs,
    input  logic [RW-1:0]       de_rd,
    input  logic                de_reg_write,
    input  logic                de_long,
    input  logic [NREAD*RW-1:0] ex_rs,
    input  logic [RW-1:0]       ex_rd,
    input  logic [1:0]          ex_result_src,
    input  logic                ex_long,
    input  logic                ex_pc_src,
    input  logic [RW-1:0]       mem_rd,
    input  logic [RW-1:0]       wb_rd,
    input  logic                mem_reg_write,
    input  logic                wb_reg_write,
    input  logic                lng_done,
    input  logic [RW-1:0]       lng_done_rd,
    input  logic                stall_all,
    output logic                if_stall,
    output logic                de_stall,
    output logic                ex_stall,
    output logic                mem_stall,
    output logic                wb_stall,
    output logic                de_flush,
    output logic                ex_flush,
    output logic [NREAD*2-1:0]  ex_fwd,
    output logic [NREGS-1:0]    pending,
    output logic [OW-1:0]       out_cnt,
    output logic [PERF_W-1:0]   stall_cycles
);

    logic [NREGS-1:0]  pending_q, pending_d;
    logic [OW-1:0]     out_cnt_q, out_cnt_d;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [RW-1:0] de_rs_a [NREAD];
    fwd_sel_e      fwd_a   [NREAD];

    for (genvar g = 0; g < NREAD; g++) begin : g_op
        assign de_rs_a[g] = de_rs[g*RW +: RW];

        fwd_select #(.RW(RW)) u_fwd (
            .rs            (ex_rs[g*RW +: RW]),
            .mem_rd        (mem_rd),
            .mem_reg_write (mem_reg_write),
            .wb_rd         (wb_rd),
            .wb_reg_write  (wb_reg_write),
            .lng_done      (lng_done),
            .lng_done_rd   (lng_done_rd),
            .sel           (fwd_a[g])
        );

        assign ex_fwd[g*2 +: 2] = reset_n ? fwd_a[g] : FWD_RF;
    end

    logic src_hz, ldm_match, ldm_hazard, waw_hz, cap_hz, sb_hazard, any_hz, de_stall_raw;

    // A completing long op releases its readers the same cycle (its result is on the lng bus).
    always_comb begin
        src_hz    = 1'b0;
        ldm_match = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            if ((de_rs_a[i] != '0) && pending_q[de_rs_a[i]] &&
                !(lng_done && (lng_done_rd == de_rs_a[i]))) begin
                src_hz = 1'b1;
            end
            if (de_rs_a[i] == ex_rd) begin
                ldm_match = 1'b1;
            end
        end
    end

    assign ldm_hazard   = (ex_result_src == RES_SRC_LOAD) && !ex_long && (ex_rd != '0) && ldm_match;
    assign waw_hz       = de_reg_write && (de_rd != '0) && pending_q[de_rd];
    assign cap_hz       = de_long && (out_cnt_q == OW'(MAX_OUT)) && !lng_done;
    assign sb_hazard    = src_hz | waw_hz | cap_hz;
    assign any_hz       = ldm_hazard | sb_hazard;
    assign de_stall_raw = stall_all | any_hz;

    assign if_stall  = !reset_n | de_stall_raw;
    assign de_stall  = !reset_n | de_stall_raw;
    assign ex_stall  = !reset_n | stall_all;
    assign mem_stall = !reset_n | stall_all;
    assign wb_stall  = !reset_n | stall_all;
    assign de_flush  = !reset_n | ex_pc_src;
    assign ex_flush  = !reset_n | ex_pc_src | (any_hz & !stall_all);

    logic issue_vld, done_vld;

    // Stray completions (not pending, or nothing in flight) are dropped rather than corrupting the count.
    assign issue_vld = ex_long && !stall_all && (ex_rd != '0);
    assign done_vld  = lng_done && pending_q[lng_done_rd] && (out_cnt_q != '0);

    always_comb begin
        pending_d = pending_q;
        if (done_vld) begin
            pending_d[lng_done_rd] = 1'b0;
        end
        if (issue_vld) begin
            pending_d[ex_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        out_cnt_d = out_cnt_q;
        if (issue_vld && !done_vld) begin
            out_cnt_d = out_cnt_q + OW'(1);
        end else if (!issue_vld && done_vld) begin
            out_cnt_d = out_cnt_q - OW'(1);
        end

        stall_cycles_d = stall_cycles_q;
        if (de_stall_raw && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q      <= '0;
            out_cnt_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            pending_q      <= pending_d;
            out_cnt_q      <= out_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pending      = pending_q;
    assign out_cnt      = out_cnt_q;
    assign stall_cycles = stall_cycles_q;

    a_done_legal: assert property (@(posedge clk) disable iff (!reset_n)
        lng_done |-> (pending_q[lng_done_rd] && (out_cnt_q != '0)));

    a_no_same_reg: assert property (@(posedge clk) disable iff (!reset_n)
        !(issue_vld && lng_done && (lng_done_rd == ex_rd)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table for combinational paths, hand sequences for state.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  de_rs, ex_rs;
    logic [4:0]  de_rd, ex_rd, mem_rd, wb_rd, lng_done_rd;
    logic        de_reg_write, de_long, ex_long, ex_pc_src;
    logic [1:0]  ex_result_src;
    logic        mem_reg_write, wb_reg_write, lng_done, stall_all;
    logic        if_stall, de_stall, ex_stall, mem_stall, wb_stall, de_flush, ex_flush;
    logic [3:0]  ex_fwd;
    logic [31:0] pending;
    logic [2:0]  out_cnt;
    logic [3:0]  stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    hazard_scoreboard #(.NREGS(32), .NREAD(2), .MAX_OUT(4), .PERF_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .de_rs(de_rs), .de_rd(de_rd), .de_reg_write(de_reg_write), .de_long(de_long),
        .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_result_src(ex_result_src), .ex_long(ex_long),
        .ex_pc_src(ex_pc_src), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .lng_done(lng_done), .lng_done_rd(lng_done_rd), .stall_all(stall_all),
        .if_stall(if_stall), .de_stall(de_stall), .ex_stall(ex_stall),
        .mem_stall(mem_stall), .wb_stall(wb_stall),
        .de_flush(de_flush), .ex_flush(ex_flush), .ex_fwd(ex_fwd),
        .pending(pending), .out_cnt(out_cnt), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct packed {
        int de_rs0, de_rs1, de_long;
        int ex_rs0, ex_rs1, ex_rd, src, pc_src;
        int mem_rd, mem_we, wb_rd, wb_we, stall_all;
        int exp_stall, exp_dflush, exp_xflush, exp_fwd;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        de_rs = '0; de_rd = '0; de_reg_write = 0; de_long = 0;
        ex_rs = '0; ex_rd = '0; ex_result_src = 2'b00; ex_long = 0; ex_pc_src = 0;
        mem_rd = '0; wb_rd = '0; mem_reg_write = 0; wb_reg_write = 0;
        lng_done = 0; lng_done_rd = '0; stall_all = 0;
    endtask

    initial begin
        //            de0 de1 lng ex0 ex1 rd src pc mem mwe wb wwe sa  stl df xf fwd
        vecs[0]  = '{ 0,  0,  0,  0,  0,  0, 0,  0, 0,  0,  0, 0,  0,  0,  0, 0, 0 };
        vecs[1]  = '{ 5,  1,  0,  0,  0,  5, 1,  0, 0,  0,  0, 0,  0,  1,  0, 1, 0 };
        vecs[2]  = '{ 2,  5,  0,  0,  0,  5, 1,  0, 0,  0,  0, 0,  0,  1,  0, 1, 0 };
        vecs[3]  = '{ 0,  0,  0,  0,  0,  0, 1,  0, 0,  0,  0, 0,  0,  0,  0, 0, 0 };
        vecs[4]  = '{ 6,  7,  0,  0,  0,  5, 1,  0, 0,  0,  0, 0,  0,  0,  0, 0, 0 };
        vecs[5]  = '{ 5,  0,  0,  0,  0,  5, 0,  0, 0,  0,  0, 0,  0,  0,  0, 0, 0 };
        vecs[6]  = '{ 0,  0,  0,  0,  0,  0, 0,  1, 0,  0,  0, 0,  0,  0,  1, 1, 0 };
        vecs[7]  = '{ 5,  1,  0,  0,  0,  5, 1,  0, 0,  0,  0, 0,  1,  1,  0, 0, 0 };
        vecs[8]  = '{ 0,  0,  0,  3,  0,  0, 0,  0, 3,  1,  3, 1,  0,  0,  0, 0, 2 };
        vecs[9]  = '{ 0,  0,  0,  0,  4,  0, 0,  0, 0,  0,  4, 1,  0,  0,  0, 0, 4 };
        vecs[10] = '{ 0,  0,  0,  3,  0,  0, 0,  0, 3,  0,  3, 1,  0,  0,  0, 0, 1 };
        vecs[11] = '{ 0,  0,  0,  0,  0,  0, 0,  0, 0,  1,  0, 1,  0,  0,  0, 0, 0 };
        vecs[12] = '{ 0,  0,  0,  9,  9,  0, 0,  0, 9,  1,  0, 0,  0,  0,  0, 0, 10 };
        vecs[13] = '{ 0,  0,  1,  0,  0,  0, 0,  0, 0,  0,  0, 0,  0,  0,  0, 0, 0 };
        vecs[14] = '{ 5,  1,  0,  0,  0,  5, 1,  1, 0,  0,  0, 0,  0,  1,  1, 1, 0 };
        vecs[15] = '{ 0,  0,  0,  0,  0,  0, 0,  0, 0,  0,  0, 0,  1,  1,  0, 0, 0 };

        // Reset state, with a live forwarding match that must be masked.
        clear_inputs();
        reset_n = 0;
        mem_rd = 5'd3; mem_reg_write = 1; ex_rs = {5'd0, 5'd3};
        #2;
        chk("rst.stalls", 32'({if_stall, de_stall, ex_stall, mem_stall, wb_stall}), 32'h1f);
        chk("rst.flush", 32'({de_flush, ex_flush}), 32'h3);
        chk("rst.fwd", 32'(ex_fwd), 32'h0);
        chk("rst.pending", pending, 32'h0);
        chk("rst.out_cnt", 32'(out_cnt), 32'h0);
        chk("rst.stall_cycles", 32'(stall_cycles), 32'h0);
        step(); step();
        clear_inputs();
        reset_n = 1;

        // Combinational vector table (scoreboard empty throughout).
        for (int i = 0; i < 16; i++) begin
            step();
            de_rs         = {5'(vecs[i].de_rs1), 5'(vecs[i].de_rs0)};
            de_long       = 1'(vecs[i].de_long);
            ex_rs         = {5'(vecs[i].ex_rs1), 5'(vecs[i].ex_rs0)};
            ex_rd         = 5'(vecs[i].ex_rd);
            ex_result_src = 2'(vecs[i].src);
            ex_pc_src     = 1'(vecs[i].pc_src);
            mem_rd        = 5'(vecs[i].mem_rd);
            mem_reg_write = 1'(vecs[i].mem_we);
            wb_rd         = 5'(vecs[i].wb_rd);
            wb_reg_write  = 1'(vecs[i].wb_we);
            stall_all     = 1'(vecs[i].stall_all);
            #1;
            chk($sformatf("v%0d.de_stall", i), 32'(de_stall), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d.if_stall", i), 32'(if_stall), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d.back_stall", i), 32'({ex_stall, mem_stall, wb_stall}),
                32'(vecs[i].stall_all != 0 ? 3'b111 : 3'b000));
            chk($sformatf("v%0d.de_flush", i), 32'(de_flush), 32'(vecs[i].exp_dflush));
            chk($sformatf("v%0d.ex_flush", i), 32'(ex_flush), 32'(vecs[i].exp_xflush));
            chk($sformatf("v%0d.ex_fwd", i), 32'(ex_fwd), 32'(vecs[i].exp_fwd));
        end
        step();
        clear_inputs();
        chk("tbl.pending", pending, 32'h0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in DE.
        step();
        ex_result_src = 2'b01; ex_rd = 5'd5; de_rs = {5'd1, 5'd5}; #1;
        chk("ldu.stall", 32'(de_stall), 32'h1);
        chk("ldu.ex_flush", 32'(ex_flush), 32'h1);
        step();
        ex_result_src = 2'b00; ex_rd = 5'd0; mem_rd = 5'd5; mem_reg_write = 1; #1;
        chk("ldu.bubble_stall", 32'(de_stall), 32'h0);
        chk("ldu.bubble_flush", 32'(ex_flush), 32'h0);
        step();
        mem_rd = 5'd0; mem_reg_write = 0; wb_rd = 5'd5; wb_reg_write = 1;
        de_rs = '0; ex_rs = {5'd1, 5'd5}; #1;
        chk("ldu.fwd", 32'(ex_fwd), 32'h1);
        step();
        clear_inputs();

        // Long div x7 issues, dependent waits until its completion.
        step();
        ex_long = 1; ex_rd = 5'd7; de_rs = {5'd2, 5'd3}; #1;
        chk("div.issue_stall", 32'(de_stall), 32'h0);
        step();
        ex_long = 0; ex_rd = 5'd0; de_rs = {5'd2, 5'd7}; #1;
        chk("div.pending", pending, 32'h80);
        chk("div.out_cnt", 32'(out_cnt), 32'h1);
        chk("div.stall", 32'(de_stall), 32'h1);
        chk("div.ex_flush", 32'(ex_flush), 32'h1);
        step();
        chk("div.stall2", 32'(de_stall), 32'h1);
        lng_done = 1; lng_done_rd = 5'd7; ex_rs = {5'd0, 5'd7}; #1;
        chk("div.release", 32'(de_stall), 32'h0);
        chk("div.fwd_lng", 32'(ex_fwd), 32'h3);
        step();
        clear_inputs(); #1;
        chk("div.cleared", pending, 32'h0);
        chk("div.cnt0", 32'(out_cnt), 32'h0);

        // Outstanding limit, WAW, same-cycle issue/complete.
        for (int r = 10; r < 14; r++) begin
            ex_long = 1; ex_rd = 5'(r);
            step();
        end
        ex_long = 0; ex_rd = '0;
        de_long = 1; de_reg_write = 1; de_rd = 5'd14; #1;
        chk("cap.pending", pending, 32'h3c00);
        chk("cap.out_cnt", 32'(out_cnt), 32'h4);
        chk("cap.stall", 32'(de_stall), 32'h1);
        lng_done = 1; lng_done_rd = 5'd10; #1;
        chk("cap.release", 32'(de_stall), 32'h0);
        step();
        de_long = 0; de_rd = 5'd11; lng_done_rd = 5'd11; #1;
        chk("waw.pending", pending, 32'h3800);
        chk("waw.out_cnt", 32'(out_cnt), 32'h3);
        chk("waw.stall", 32'(de_stall), 32'h1);
        step();
        de_reg_write = 0; de_rd = '0; de_rs = {5'd0, 5'd12}; lng_done_rd = 5'd12; #1;
        chk("raw_rel.pending", pending, 32'h3000);
        chk("raw_rel.stall", 32'(de_stall), 32'h0);
        step();
        de_rs = '0; ex_long = 1; ex_rd = 5'd20; lng_done_rd = 5'd13; #1;
        chk("both.pre_cnt", 32'(out_cnt), 32'h1);
        step();
        ex_long = 0; ex_rd = '0; lng_done_rd = 5'd20; #1;
        chk("both.pending", pending, 32'h0010_0000);
        chk("both.out_cnt", 32'(out_cnt), 32'h1);
        step();
        clear_inputs(); #1;
        chk("both.drained", 32'(out_cnt), 32'h0);

        // Asynchronous reset with x4 and x7 in flight.
        ex_long = 1; ex_rd = 5'd4;
        step();
        ex_rd = 5'd7;
        step();
        ex_long = 0; ex_rd = '0; #1;
        chk("mid.pending", pending, 32'h90);
        chk("mid.out_cnt", 32'(out_cnt), 32'h2);
        reset_n = 0; #1;
        chk("mid.rst_pending", pending, 32'h0);
        chk("mid.rst_cnt", 32'(out_cnt), 32'h0);
        chk("mid.rst_stalls", 32'({if_stall, de_stall, ex_stall, mem_stall, wb_stall}), 32'h1f);
        chk("mid.rst_flush", 32'({de_flush, ex_flush}), 32'h3);
        step(); step();
        reset_n = 1;

        // Global freeze blocks issue; 4-bit stall counter saturates.
        step(); #1;
        chk("perf.zero", 32'(stall_cycles), 32'h0);
        stall_all = 1; ex_long = 1; ex_rd = 5'd9;
        step();
        chk("frz.pending", pending, 32'h0);
        chk("frz.out_cnt", 32'(out_cnt), 32'h0);
        chk("perf.one", 32'(stall_cycles), 32'h1);
        repeat (13) step();
        chk("perf.14", 32'(stall_cycles), 32'he);
        repeat (6) step();
        chk("perf.sat", 32'(stall_cycles), 32'hf);
        clear_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
